// File: rtl/mac_dot_sequencer.sv
`default_nettype none
// mac_dot_sequencer: steps an external combinational 8x8+24 MAC through one runtime-length dot product.
// Optional output ReLU enabled by defining MAC_SEQ_RELU_EN.  Rev 1.0
module mac_dot_sequencer #(
  parameter int DATA_W = 8,
  parameter int PSUM_W = 24,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [PSUM_W-1:0] psum_init,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_ifmap,
  input  logic [DATA_W-1:0] in_filter,
  output logic [DATA_W-1:0] mac_ifmap,
  output logic [DATA_W-1:0] mac_filter,
  output logic [PSUM_W-1:0] mac_psum,
  input  logic [PSUM_W-1:0] mac_updated,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PSUM_W-1:0] out_psum,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t            state;
  logic [PSUM_W-1:0] acc;
  logic [LEN_W-1:0]  cnt;
  logic [LEN_W-1:0]  len;

  // ReLU touches only the presented result; acc keeps the raw signed sum.
  function automatic logic [PSUM_W-1:0] shape_out(input logic [PSUM_W-1:0] v);
`ifdef MAC_SEQ_RELU_EN
    return v[PSUM_W-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  assign mac_ifmap  = in_ifmap;
  assign mac_filter = in_filter;
  assign mac_psum   = acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      acc       <= '0;
      cnt       <= '0;
      len       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_psum  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            acc  <= psum_init;
            busy <= 1'b1;
            if (cfg_len != '0) begin
              len      <= cfg_len;
              cnt      <= '0;
              in_ready <= 1'b1;
              state    <= S_ACC;
            end else begin
              out_valid <= 1'b1;
              out_psum  <= shape_out(psum_init);
              state     <= S_OUT;
            end
          end
        end
        S_ACC: begin
          if (in_valid && in_ready) begin
            acc <= mac_updated;
            cnt <= cnt + 1'b1;
            // Result is registered straight from the MAC so out_valid rises right after the last beat.
            if (cnt == len - 1'b1) begin
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_psum  <= shape_out(mac_updated);
              state     <= S_OUT;
            end
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mac_dot_sequencer.sv
`default_nettype none
// tb_mac_dot_sequencer: randomized self-checking bench against a dot-product reference model.
module tb_mac_dot_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  cfg_len = '0;
  logic [23:0] psum_init = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_ifmap = '0;
  logic [7:0]  in_filter = '0;
  logic signed [7:0] mac_ifmap;
  logic signed [7:0] mac_filter;
  logic [23:0] mac_psum;
  logic [23:0] mac_updated;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [23:0] out_psum;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_pass   = 0;

  logic signed [7:0] pa_if [0:255];
  logic signed [7:0] pa_fl [0:255];

  always #5 clk = ~clk;

  // External MAC: psum + ifmap*filter, wrapping at 24 bits.
  assign mac_updated = mac_psum + 24'(int'(mac_ifmap) * int'(mac_filter));

  mac_dot_sequencer #(.DATA_W(8), .PSUM_W(24), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .psum_init(psum_init),
    .in_valid(in_valid), .in_ready(in_ready), .in_ifmap(in_ifmap), .in_filter(in_filter),
    .mac_ifmap(mac_ifmap), .mac_filter(mac_filter), .mac_psum(mac_psum), .mac_updated(mac_updated),
    .out_valid(out_valid), .out_ready(out_ready), .out_psum(out_psum), .busy(busy), .done(done)
  );

  function automatic logic [23:0] ref_dot(input logic [23:0] init, input int len);
    logic [23:0] s;
    s = init;
    for (int i = 0; i < len; i++) s = s + 24'(int'(pa_if[i]) * int'(pa_fl[i]));
`ifdef MAC_SEQ_RELU_EN
    if (s[23]) s = '0;
`endif
    return s;
  endfunction

  // Caller is at a negedge; start is raised immediately. Returns when out_valid is seen.
  task automatic drive_job(input int len, input logic [23:0] init, input int gmin, input int gmax,
                           output logic [23:0] res, output int lat, output bit to);
    int idx, gap, cyc;
    start = 1'b1; cfg_len = 8'(len); psum_init = init;
    @(negedge clk);
    start = 1'b0; idx = 0; cyc = 0;
    gap = $urandom_range(gmax, gmin);
    while (idx < len && cyc < 5000) begin
      if (gap > 0) begin
        in_valid = 1'b0; in_ifmap = 8'($urandom); in_filter = 8'($urandom); gap--;
      end else begin
        in_valid = 1'b1; in_ifmap = pa_if[idx]; in_filter = pa_fl[idx];
      end
      if (in_valid && in_ready) begin
        idx++; gap = $urandom_range(gmax, gmin);
      end
      @(negedge clk); cyc++;
    end
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 5000) begin @(negedge clk); lat++; end
    to = !out_valid;
    res = out_psum;
  endtask

  task automatic finish_job(output logic d1, output logic ov, output logic d2);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; d1 = done; ov = out_valid;
    @(negedge clk);
    d2 = done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    n_checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b exp 0", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else n_pass++;
    n_checks++; if (out_psum !== 24'h0) $display("FAIL reset_out_psum got %h exp 0", out_psum); else n_pass++;
    n_checks++; if (mac_psum !== 24'h0) $display("FAIL reset_acc got %h exp 0", mac_psum); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_t1();
    logic [23:0] r; int lat; bit to; logic d1, ov, d2;
    pa_if[0] = 8'sd2;    pa_fl[0] = 8'sd3;
    pa_if[1] = -8'sd4;   pa_fl[1] = 8'sd5;
    pa_if[2] = 8'sd127;  pa_fl[2] = -8'sd128;
    drive_job(3, 24'h0, 0, 0, r, lat, to);
    n_checks++; if (to !== 1'b0) $display("FAIL t1_timeout got %b exp 0", to); else n_pass++;
    n_checks++; if (r !== ref_dot(24'h0, 3)) $display("FAIL t1_psum got %h exp %h", r, ref_dot(24'h0, 3)); else n_pass++;
    n_checks++; if (lat !== 0) $display("FAIL t1_latency got %0d exp 0", lat); else n_pass++;
    finish_job(d1, ov, d2);
    n_checks++; if (d1 !== 1'b1) $display("FAIL t1_done_pulse got %b exp 1", d1); else n_pass++;
    n_checks++; if (d2 !== 1'b0) $display("FAIL t1_done_once got %b exp 0", d2); else n_pass++;
    n_checks++; if (ov !== 1'b0) $display("FAIL t1_out_valid_drop got %b exp 0", ov); else n_pass++;
  endtask

  task automatic test_zero_len_t2();
    logic [23:0] r; int lat; bit to; logic d1, ov, d2;
    drive_job(0, 24'h555555, 0, 0, r, lat, to);
    n_checks++; if (lat !== 0 || to !== 1'b0) $display("FAIL t2_latency got %0d exp 0", lat); else n_pass++;
    n_checks++; if (r !== 24'h555555) $display("FAIL t2_psum got %h exp 555555", r); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL t2_in_ready got %b exp 0", in_ready); else n_pass++;
    finish_job(d1, ov, d2);
    n_checks++; if (d1 !== 1'b1) $display("FAIL t2_done got %b exp 1", d1); else n_pass++;
  endtask

  task automatic test_gaps_t3();
    logic [23:0] r; int lat; bit to; logic d1, ov, d2;
    pa_if[0] = -8'sd128; pa_fl[0] = -8'sd128;
    pa_if[1] = -8'sd128; pa_fl[1] = -8'sd128;
    drive_job(2, 24'hFFFFFF, 3, 3, r, lat, to);
    n_checks++; if (to !== 1'b0) $display("FAIL t3_timeout got %b exp 0", to); else n_pass++;
    n_checks++; if (r !== 24'd32767) $display("FAIL t3_psum got %h exp %h", r, 24'd32767); else n_pass++;
    n_checks++; if (lat !== 0) $display("FAIL t3_latency got %0d exp 0", lat); else n_pass++;
    finish_job(d1, ov, d2);
  endtask

  task automatic test_wrap_t4();
    logic [23:0] r; int lat; bit to; logic d1, ov, d2;
    pa_if[0] = 8'sd1; pa_fl[0] = 8'sd1;
    drive_job(1, 24'h7FFFFF, 0, 0, r, lat, to);
`ifdef MAC_SEQ_RELU_EN
    n_checks++; if (r !== 24'h0) $display("FAIL t4_wrap_relu got %h exp 0", r); else n_pass++;
`else
    n_checks++; if (r !== 24'h800000) $display("FAIL t4_wrap got %h exp 800000", r); else n_pass++;
`endif
    n_checks++; if (mac_psum !== 24'h800000) $display("FAIL t4_acc got %h exp 800000", mac_psum); else n_pass++;
    finish_job(d1, ov, d2);
    n_checks++; if (d1 !== 1'b1) $display("FAIL t4_done got %b exp 1", d1); else n_pass++;
  endtask

  task automatic test_backpressure_t5();
    logic [23:0] r, exp; int lat; bit to; logic d1, ov, d2;
    for (int i = 0; i < 3; i++) begin pa_if[i] = 8'($urandom); pa_fl[i] = 8'($urandom); end
    exp = ref_dot(24'h000123, 3);
    drive_job(3, 24'h000123, 0, 1, r, lat, to);
    for (int c = 0; c < 5; c++) begin
      start = 1'b1; cfg_len = 8'($urandom_range(4, 1)); psum_init = 24'($urandom);
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b1) $display("FAIL t5_valid_hold c%0d got %b exp 1", c, out_valid); else n_pass++;
      n_checks++; if (busy !== 1'b1) $display("FAIL t5_busy c%0d got %b exp 1", c, busy); else n_pass++;
      n_checks++; if (out_psum !== exp) $display("FAIL t5_stable c%0d got %h exp %h", c, out_psum, exp); else n_pass++;
    end
    // Handshake with start asserted in the same cycle: start must be dropped.
    cfg_len = 8'd1; psum_init = 24'd7; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; out_ready = 1'b0;
    n_checks++; if (done !== 1'b1) $display("FAIL t5_done got %b exp 1", done); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL t5_start_ignored got busy=%b exp 0", busy); else n_pass++;
    pa_if[0] = 8'sd5; pa_fl[0] = -8'sd6;
    drive_job(1, 24'd100, 0, 0, r, lat, to);
    n_checks++; if (to !== 1'b0 || r !== 24'd70) $display("FAIL t5_next_job got %h exp %h", r, 24'd70); else n_pass++;
    finish_job(d1, ov, d2);
    n_checks++; if (d1 !== 1'b1) $display("FAIL t5_next_done got %b exp 1", d1); else n_pass++;
  endtask

  task automatic test_reset_mid_t6();
    logic [23:0] r; int lat; bit to; logic d1, ov, d2;
    start = 1'b1; cfg_len = 8'd4; psum_init = 24'd50;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_ifmap = 8'd9; in_filter = 8'd9;
    @(negedge clk); @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (busy !== 1'b1 || in_ready !== 1'b1) $display("FAIL t6_pre_busy got %b exp 1", busy); else n_pass++;
    #1 rst = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL t6_in_ready got %b exp 0", in_ready); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL t6_busy got %b exp 0", busy); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL t6_out_valid got %b exp 0", out_valid); else n_pass++;
    n_checks++; if (mac_psum !== 24'h0) $display("FAIL t6_acc got %h exp 0", mac_psum); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pa_if[0] = 8'sd3; pa_fl[0] = 8'sd3;
    drive_job(1, 24'd7, 0, 0, r, lat, to);
    n_checks++; if (to !== 1'b0 || r !== 24'd16) $display("FAIL t6_new_job got %h exp %h", r, 24'd16); else n_pass++;
    finish_job(d1, ov, d2);
  endtask

  task automatic test_random();
    logic [23:0] r, init, exp; int len, lat; bit to; logic d1, ov, d2;
    for (int j = 0; j < 25; j++) begin
      len = $urandom_range(12, 0);
      init = 24'($urandom);
      for (int i = 0; i < len; i++) begin pa_if[i] = 8'($urandom); pa_fl[i] = 8'($urandom); end
      exp = ref_dot(init, len);
      drive_job(len, init, 0, 2, r, lat, to);
      n_checks++; if (to !== 1'b0 || r !== exp) $display("FAIL rand_psum job%0d len%0d got %h exp %h", j, len, r, exp); else n_pass++;
      n_checks++; if (lat !== 0) $display("FAIL rand_latency job%0d got %0d exp 0", j, lat); else n_pass++;
      finish_job(d1, ov, d2);
      n_checks++; if (d1 !== 1'b1 || d2 !== 1'b0) $display("FAIL rand_done job%0d got %b%b exp 10", j, d1, d2); else n_pass++;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_t1();
    test_zero_len_t2();
    test_gaps_t3();
    test_wrap_t4();
    test_backpressure_t5();
    test_reset_mid_t6();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
